cc_cond_unit: RTL and testbench
===============================

// Module: cc_cond_unit
// PURPOSE
//  Receiving end of the ALU flag interface. Captures OF/result from the 64-bit
//  add/sub ALU into the Y86 condition-code register (ZF, SF, OF) on OPq.
//  Evaluates jXX/cmovXX conditions from the stored codes.
//  Sits in the SEQ execute stage between the ALU and PC-update / register write-back.
// PARAMETERS
//  WIDTH     64      ALU result width; ZF/SF derive from this width
//  RESET_CC  3'b100  CC value after reset, order {ZF,SF,OF}
// PORTS
//  clk       in   1      single clock, rising edge
//  reset     in   1      synchronous, active-high
//  set_cc    in   1      high when icode==OPq and the instruction commits this cycle
//  stall     in   1      high: hold CC and status, ignore set_cc
//  valE      in   WIDTH  ALU result
//  alu_of    in   1      ALU signed-overflow flag
//  icode     in   4      current instruction code
//  ifun      in   4      current function code (condition selector)
//  cc        out  3      registered {ZF,SF,OF}
//  cnd       out  1      condition true for current jXX/cmovXX (combinational)
//  cond_err  out  1      sticky: invalid ifun seen on jXX/cmovXX
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Reset wins over all inputs.
//  - Reset values: cc=RESET_CC (ZF=1, SF=0, OF=0); cond_err=0.
//  - CC update at posedge when set_cc & ~stall & ~reset:
//      ZF<=(valE==0); SF<=valE[WIDTH-1]; OF<=alu_of.
//    Otherwise cc holds. Latency: new flags visible 1 cycle after the OPq edge.
//  - cnd is combinational from the registered cc, not the incoming valE.
//    An OPq never tests its own flags, so no forwarding path exists.
//  - cnd = 0 unless icode is IJXX (7) or ICMOVXX (2). IRRMOVQ shares icode 2,
//    with ifun 0 giving cnd=1. Per ifun:
//      0 YES  1
//      1 LE   (SF^OF)|ZF
//      2 L    SF^OF
//      3 E    ZF
//      4 NE   ~ZF
//      5 GE   ~(SF^OF)
//      6 G    ~(SF^OF)&~ZF
//    ifun>6: cnd=0, and cond_err<=1 at the next posedge unless stall.
//  - cond_err is sticky; only reset clears it.
//  - set_cc with icode!=OPq is legal. It still updates CC (the decoder owns qualification).
//  - stall & set_cc together: CC unchanged; after stall drops, the held OPq
//    re-asserts set_cc and updates.
//  - reset asserted mid-sequence: next edge restores RESET_CC regardless of set_cc.
//  - Flags reflect full WIDTH; no truncation. valE=0 with alu_of=1 gives ZF=1, OF=1.
//  - No X propagation: cnd is defined for all icode/ifun values.
// STRUCTURE
//  - Shared package/header y86_consts: icode constants
//    (IRRMOVQ/ICMOVXX=4'h2, IOPQ=4'h6, IJXX=4'h7); condition constants
//    C_YES..C_G = 4'h0..4'h6; CC bit indices ZF=2, SF=1, OF=0.
//  - One sub-module cond_eval (pure combinational: cc[2:0], ifun -> cnd, bad_ifun).
//    Instantiated once. The top holds the CC register, the sticky error, and icode gating.
// TESTING
//  1 reset=1 for 2 cycles with set_cc=1, valE=5 -> cc=3'b100; cond_err=0; icode=7, ifun=3 -> cnd=1
//  2 set_cc=1, valE=64'hFFFF_FFFF_FFFF_FFFE, alu_of=0 -> next cycle cc=3'b010;
//    jXX ifun=2 (L) cnd=1; ifun=6 (G) cnd=0; ifun=5 (GE) cnd=0
//  3 set_cc=1, valE=64'h8000_0000_0000_0000, alu_of=1 -> cc=3'b011;
//    L cnd=0; GE cnd=1; cmovXX (icode 2) ifun=4 (NE) cnd=1
//  4 cc=3'b100; stall=1, set_cc=1, valE=7 -> cc stays 3'b100;
//    drop stall, same inputs -> next cycle cc=3'b000
//  5 icode=7, ifun=4'h9 -> cnd=0 same cycle, cond_err=1 next cycle and stays 1;
//    only reset clears it
//  6 icode=6, ifun=0 -> cnd=0; reset asserted together with set_cc, valE=0,
//    alu_of=1 -> cc=3'b100 (reset wins)

Source files
------------

// File: rtl/cc_cond_unit_pkg.sv
// y86_consts: shared Y86 icode, condition-code selector and CC bit-index constants
package y86_consts;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] ICMOVXX = 4'h2;
  localparam logic [3:0] IOPQ = 4'h6;
  localparam logic [3:0] IJXX = 4'h7;
  localparam logic [3:0] C_YES = 4'h0;
  localparam logic [3:0] C_LE = 4'h1;
  localparam logic [3:0] C_L = 4'h2;
  localparam logic [3:0] C_E = 4'h3;
  localparam logic [3:0] C_NE = 4'h4;
  localparam logic [3:0] C_GE = 4'h5;
  localparam logic [3:0] C_G = 4'h6;
  localparam int ZF = 2;
  localparam int SF = 1;
  localparam int OF = 0;
endpackage

// File: rtl/cc_cond_unit_cond_eval.sv
// cond_eval: combinational jXX/cmovXX condition from {ZF,SF,OF} and ifun; flags ifun>6 as bad
module cond_eval
  import y86_consts::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd,
  output logic       bad_ifun
);
  logic lt;
  assign lt = cc[SF] ^ cc[OF];
  assign cnd = ifun == C_YES ? 1'b1 :
               ifun == C_LE  ? lt | cc[ZF] :
               ifun == C_L   ? lt :
               ifun == C_E   ? cc[ZF] :
               ifun == C_NE  ? ~cc[ZF] :
               ifun == C_GE  ? ~lt :
               ifun == C_G   ? ~lt & ~cc[ZF] : 1'b0;
  assign bad_ifun = ifun > C_G;
endmodule

// File: rtl/cc_cond_unit.sv
// cc_cond_unit: Y86 CC register (clk,reset,set_cc,stall,valE,alu_of in; cc out), gated jXX/cmovXX cnd and sticky cond_err
module cc_cond_unit
  import y86_consts::*;
#(
  parameter int         WIDTH    = 64,
  parameter logic [2:0] RESET_CC = 3'b100
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_cc,
  input  logic             stall,
  input  logic [WIDTH-1:0] valE,
  input  logic             alu_of,
  input  logic [3:0]       icode,
  input  logic [3:0]       ifun,
  output logic [2:0]       cc,
  output logic             cnd,
  output logic             cond_err
);
  logic is_cond, raw_cnd, bad_ifun;
  assign is_cond = icode == IJXX || icode == ICMOVXX;
  cond_eval u_eval (
    .cc       (cc),
    .ifun     (ifun),
    .cnd      (raw_cnd),
    .bad_ifun (bad_ifun)
  );
  assign cnd = is_cond & raw_cnd;
  always_ff @(posedge clk) begin
    if (reset) begin
      cc <= RESET_CC;
      cond_err <= 1'b0;
    end else if (!stall) begin
      if (set_cc) cc <= {valE == '0, valE[WIDTH-1], alu_of};
      if (is_cond && bad_ifun) cond_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cc_cond_unit.sv
// tb_cc_cond_unit: randomized and directed self-check of cc_cond_unit against a flag-level reference model
module tb_cc_cond_unit;
  logic        clk = 0;
  logic        reset = 1, set_cc = 0, stall = 0, alu_of = 0;
  logic [63:0] valE = 0;
  logic [3:0]  icode = 0, ifun = 0;
  logic [2:0]  cc;
  logic        cnd, cond_err;
  int          errors = 0, checks = 0;
  logic [2:0]  m_cc = 3'b100;
  logic        m_err = 0;

  cc_cond_unit dut (
    .clk(clk), .reset(reset), .set_cc(set_cc), .stall(stall), .valE(valE),
    .alu_of(alu_of), .icode(icode), .ifun(ifun), .cc(cc), .cnd(cnd), .cond_err(cond_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_cnd(input logic [2:0] c, input logic [3:0] ic, input logic [3:0] fn);
    bit zero = c[2], less = c[1] != c[0];
    if (ic != 4'd7 && ic != 4'd2) return 0;
    case (fn)
      0: return 1;
      1: return less || zero;
      2: return less;
      3: return zero;
      4: return !zero;
      5: return !less;
      6: return !less && !zero;
      default: return 0;
    endcase
  endfunction

  task automatic cyc(input logic r, input logic s, input logic st, input logic [63:0] v,
                     input logic o, input logic [3:0] ic, input logic [3:0] fn);
    reset = r; set_cc = s; stall = st; valE = v; alu_of = o; icode = ic; ifun = fn;
    #1 check("cnd", cnd, ref_cnd(m_cc, ic, fn));
    @(posedge clk);
    if (r) begin
      m_cc = 3'b100;
      m_err = 0;
    end else if (!st) begin
      if (s) m_cc = {v == 0, v[63], o};
      if ((ic == 7 || ic == 2) && fn > 6) m_err = 1;
    end
    #1;
    check("cc", cc, m_cc);
    check("cond_err", cond_err, m_err);
  endtask

  initial begin
    reset = 1; set_cc = 1; valE = 5;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cc", cc, 3'b100);
    check("rst_err", cond_err, 0);
    icode = 7; ifun = 3;
    #1 check("rst_cnd_e", cnd, 1);
    cyc(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE, 0, 7, 3);
    check("neg_cc", cc, 3'b010);
    icode = 7; ifun = 2; #1 check("neg_L", cnd, 1);
    ifun = 6; #1 check("neg_G", cnd, 0);
    ifun = 5; #1 check("neg_GE", cnd, 0);
    cyc(0, 1, 0, 64'h8000_0000_0000_0000, 1, 6, 0);
    check("ovf_cc", cc, 3'b011);
    icode = 7; ifun = 2; #1 check("ovf_L", cnd, 0);
    ifun = 5; #1 check("ovf_GE", cnd, 1);
    icode = 2; ifun = 4; #1 check("ovf_cmov_NE", cnd, 1);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 7, 0, 6, 0);
    check("stall_cc", cc, 3'b100);
    cyc(0, 1, 0, 7, 0, 6, 0);
    check("unstall_cc", cc, 3'b000);
    cyc(0, 0, 0, 0, 0, 7, 9);
    check("bad_err", cond_err, 1);
    cyc(0, 1, 0, 3, 0, 7, 0);
    check("err_sticky", cond_err, 1);
    icode = 6; ifun = 0; #1 check("opq_cnd", cnd, 0);
    cyc(1, 1, 0, 0, 1, 6, 0);
    check("rst_wins_cc", cc, 3'b100);
    check("rst_clr_err", cond_err, 0);
    cyc(0, 1, 0, 0, 1, 6, 0);
    check("zero_of_cc", cc, 3'b101);
    for (int i = 0; i < 400; i++) begin
      logic [63:0] v;
      logic [3:0] ic, fn;
      case ($urandom_range(0, 4))
        0: v = 0;
        1: v = 64'h8000_0000_0000_0000;
        2: v = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
        default: v = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
        0: ic = 4'd2;
        1: ic = 4'd7;
        2: ic = 4'd6;
        default: ic = 4'($urandom);
      endcase
      fn = $urandom_range(0, 9) == 0 ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      cyc($urandom_range(0, 29) == 0, 1'($urandom), $urandom_range(0, 3) == 0, v, 1'($urandom), ic, fn);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
